// File: rtl/ef_psram_arb.sv
// ef_psram_arb
// Two-requester round-robin arbiter in front of a QSPI PSRAM controller.
// After reset it optionally walks the device through a three-command SPI
// power-up sequence (0x66 reset-enable, 0x99 reset, 0x35 enter-QPI). From
// then on it grants one requester at a time and turns each request into a
// single controller transaction.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rN_req/addr/wdata/    request from requester N (N = 0, 1)
//   rN_size/rN_we
//   rN_ack/rN_err         one-cycle completion pulse, err for illegal size
//   rN_rdata              read data, updated only when a read completes
//   c_start               one-cycle start pulse to the controller
//   c_addr ... c_wait_states  controller command fields (held per transaction)
//   c_done, c_rdata       controller completion and read data
//   init_done             device is in QPI mode
//   busy                  FSM is anywhere but ARB
//   dbg_state             current FSM state encoding
//
// Handshake: a requester raises rN_req with its fields stable and keeps them
// until it sees rN_ack high for one cycle; it may raise a new request after
// that. Requests seen before init_done simply wait. The controller sees
// c_start for exactly one cycle and answers with c_done, which may stay high
// for up to two further cycles; only the first high sample counts.

module ef_psram_arb #(
  parameter logic [3:0] RD_WAIT = 4'd6,
  parameter bit         INIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic [23:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [2:0]  r0_size,
  input  logic        r0_we,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic [23:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [2:0]  r1_size,
  input  logic        r1_we,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic        c_start,
  output logic [23:0] c_addr,
  output logic [31:0] c_wdata,
  output logic [2:0]  c_size,
  output logic [7:0]  c_cmd,
  output logic        c_rd_wr,
  output logic        c_qspi,
  output logic        c_qpi,
  output logic        c_short_cmd,
  output logic [3:0]  c_wait_states,
  input  logic        c_done,
  input  logic [31:0] c_rdata,
  output logic        init_done,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_INIT_ISSUE = 3'd0,
    S_INIT_WAIT  = 3'd1,
    S_INIT_GAP   = 3'd2,
    S_ARB        = 3'd3,
    S_ISSUE      = 3'd4,
    S_WAIT       = 3'd5,
    S_GAP        = 3'd6,
    S_ERR        = 3'd7
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;

  state_e      state_q;
  logic [1:0]  init_idx_q;   // which power-up command is in flight
  logic        gap_q;        // 0 = first gap cycle, 1 = second
  logic        rr_last_q;    // requester granted most recently
  logic        gnt_q;        // requester owning the transaction in flight

  logic        c_start_q;
  logic [23:0] c_addr_q;
  logic [31:0] c_wdata_q;
  logic [2:0]  c_size_q;
  logic [7:0]  c_cmd_q;
  logic        c_rd_wr_q;
  logic        c_qspi_q;
  logic        c_qpi_q;
  logic        c_short_cmd_q;
  logic [3:0]  c_wait_states_q;
  logic        r0_ack_q, r0_err_q;
  logic        r1_ack_q, r1_err_q;
  logic [31:0] r0_rdata_q, r1_rdata_q;
  logic        init_done_q;

  // Winner of the arbitration round, valid whenever gnt_any_d is high.
  logic        gnt_any_d;
  logic        gnt_sel_d;
  logic [23:0] sel_addr_d;
  logic [31:0] sel_wdata_d;
  logic [2:0]  sel_size_d;
  logic        sel_we_d;
  logic        sel_size_ok_d;
  logic [7:0]  init_cmd_d;

  always_comb begin
    gnt_any_d = r0_req | r1_req;
    // With both requesting, the one not served last wins; rr_last_q resets
    // to 1 so requester 0 is favoured first.
    if (r0_req && r1_req) begin
      gnt_sel_d = ~rr_last_q;
    end else begin
      gnt_sel_d = r1_req;
    end
    sel_addr_d    = gnt_sel_d ? r1_addr  : r0_addr;
    sel_wdata_d   = gnt_sel_d ? r1_wdata : r0_wdata;
    sel_size_d    = gnt_sel_d ? r1_size  : r0_size;
    sel_we_d      = gnt_sel_d ? r1_we    : r0_we;
    sel_size_ok_d = (sel_size_d == 3'd1) || (sel_size_d == 3'd2) ||
                    (sel_size_d == 3'd4);
    case (init_idx_q)
      2'd0:    init_cmd_d = 8'h66;
      2'd1:    init_cmd_d = 8'h99;
      default: init_cmd_d = 8'h35;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_INIT_ISSUE;
      init_idx_q      <= 2'd0;
      gap_q           <= 1'b0;
      rr_last_q       <= 1'b1;
      gnt_q           <= 1'b0;
      c_start_q       <= 1'b0;
      c_addr_q        <= '0;
      c_wdata_q       <= '0;
      c_size_q        <= '0;
      c_cmd_q         <= '0;
      c_rd_wr_q       <= 1'b0;
      c_qspi_q        <= 1'b0;
      c_qpi_q         <= 1'b0;
      c_short_cmd_q   <= 1'b0;
      c_wait_states_q <= '0;
      r0_ack_q        <= 1'b0;
      r0_err_q        <= 1'b0;
      r1_ack_q        <= 1'b0;
      r1_err_q        <= 1'b0;
      r0_rdata_q      <= '0;
      r1_rdata_q      <= '0;
      init_done_q     <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a state raises them.
      c_start_q <= 1'b0;
      r0_ack_q  <= 1'b0;
      r0_err_q  <= 1'b0;
      r1_ack_q  <= 1'b0;
      r1_err_q  <= 1'b0;

      case (state_q)
        S_INIT_ISSUE: begin
          if (INIT_EN) begin
            c_cmd_q         <= init_cmd_d;
            c_addr_q        <= '0;
            c_wdata_q       <= '0;
            c_size_q        <= '0;
            c_rd_wr_q       <= 1'b0;
            c_qspi_q        <= 1'b0;
            c_qpi_q         <= 1'b0;
            c_short_cmd_q   <= 1'b1;
            c_wait_states_q <= '0;
            c_start_q       <= 1'b1;
            state_q         <= S_INIT_WAIT;
          end else begin
            init_done_q <= 1'b1;
            c_qpi_q     <= 1'b1;
            state_q     <= S_ARB;
          end
        end

        S_INIT_WAIT: begin
          // c_start is still high in the first cycle here; a done seen then
          // cannot belong to this command.
          if (c_done && !c_start_q) begin
            gap_q   <= 1'b0;
            state_q <= S_INIT_GAP;
          end
        end

        S_INIT_GAP: begin
          if (!gap_q) begin
            gap_q <= 1'b1;
          end else if (init_idx_q == 2'd2) begin
            init_done_q   <= 1'b1;
            c_qpi_q       <= 1'b1;
            c_short_cmd_q <= 1'b0;
            state_q       <= S_ARB;
          end else begin
            init_idx_q <= init_idx_q + 2'd1;
            state_q    <= S_INIT_ISSUE;
          end
        end

        S_ARB: begin
          if (gnt_any_d) begin
            rr_last_q <= gnt_sel_d;
            gnt_q     <= gnt_sel_d;
            if (sel_size_ok_d) begin
              c_addr_q        <= sel_addr_d;
              c_wdata_q       <= sel_wdata_d;
              c_size_q        <= sel_size_d;
              c_cmd_q         <= sel_we_d ? CMD_WRITE : CMD_READ;
              c_rd_wr_q       <= ~sel_we_d;
              c_wait_states_q <= sel_we_d ? 4'd0 : RD_WAIT;
              c_short_cmd_q   <= 1'b0;
              c_qspi_q        <= 1'b0;
              c_start_q       <= 1'b1;
              state_q         <= S_ISSUE;
            end else begin
              // Illegal size: answer immediately, the controller never sees it.
              if (gnt_sel_d) begin
                r1_ack_q <= 1'b1;
                r1_err_q <= 1'b1;
              end else begin
                r0_ack_q <= 1'b1;
                r0_err_q <= 1'b1;
              end
              state_q <= S_ERR;
            end
          end
        end

        S_ISSUE: begin
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (c_done) begin
            if (gnt_q) begin
              r1_ack_q <= 1'b1;
              if (c_rd_wr_q) r1_rdata_q <= c_rdata;
            end else begin
              r0_ack_q <= 1'b1;
              if (c_rd_wr_q) r0_rdata_q <= c_rdata;
            end
            gap_q   <= 1'b0;
            state_q <= S_GAP;
          end
        end

        // Two dead cycles absorb a lingering c_done before the next grant.
        S_GAP: begin
          if (!gap_q) begin
            gap_q <= 1'b1;
          end else begin
            state_q <= S_ARB;
          end
        end

        S_ERR: begin
          state_q <= S_ARB;
        end

        default: begin
          state_q <= S_INIT_ISSUE;
        end
      endcase
    end
  end

  assign r0_ack        = r0_ack_q;
  assign r0_err        = r0_err_q;
  assign r0_rdata      = r0_rdata_q;
  assign r1_ack        = r1_ack_q;
  assign r1_err        = r1_err_q;
  assign r1_rdata      = r1_rdata_q;
  assign c_start       = c_start_q;
  assign c_addr        = c_addr_q;
  assign c_wdata       = c_wdata_q;
  assign c_size        = c_size_q;
  assign c_cmd         = c_cmd_q;
  assign c_rd_wr       = c_rd_wr_q;
  assign c_qspi        = c_qspi_q;
  assign c_qpi         = c_qpi_q;
  assign c_short_cmd   = c_short_cmd_q;
  assign c_wait_states = c_wait_states_q;
  assign init_done     = init_done_q;
  assign busy          = (state_q != S_ARB);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ef_psram_arb.sv
module tb_ef_psram_arb;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic        r0_req, r0_we, r0_ack, r0_err;
  logic [23:0] r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic [2:0]  r0_size;
  logic        r1_req, r1_we, r1_ack, r1_err;
  logic [23:0] r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic [2:0]  r1_size;
  logic        c_start, c_rd_wr, c_qspi, c_qpi, c_short_cmd, c_done;
  logic [23:0] c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic [2:0]  c_size;
  logic [7:0]  c_cmd;
  logic [3:0]  c_wait_states;
  logic        init_done, busy;
  logic [2:0]  dbg_state;

  ef_psram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_size(r0_size),
    .r0_we(r0_we), .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_size(r1_size),
    .r1_we(r1_we), .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .c_start(c_start), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
    .c_cmd(c_cmd), .c_rd_wr(c_rd_wr), .c_qspi(c_qspi), .c_qpi(c_qpi),
    .c_short_cmd(c_short_cmd), .c_wait_states(c_wait_states),
    .c_done(c_done), .c_rdata(c_rdata),
    .init_done(init_done), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not expected here (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct packed {
    logic        init;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        rd_wr;
    logic        short_cmd;
    logic        qpi;
    logic [3:0]  ws;
  } start_t;

  typedef struct packed {
    logic        who;
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  start_t      exp_start_q[$];
  ack_t        exp_ack_q[$];
  logic [31:0] model_rdata [0:1];
  logic        model_last;

  // Data the controller model returns for a read at address a.
  function automatic logic [31:0] ctrl_data(input logic [23:0] a);
    if (a == 24'h001234) return 32'hDEADBEEF;
    return {a[7:0], a} ^ 32'hA5C3_0F96;
  endfunction

  task automatic model_reset();
    model_last     = 1'b1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
  endtask

  task automatic expect_init();
    logic [7:0] cmds [0:2];
    start_t s;
    cmds[0] = 8'h66; cmds[1] = 8'h99; cmds[2] = 8'h35;
    for (int i = 0; i < 3; i++) begin
      s = '0;
      s.init      = 1'b1;
      s.cmd       = cmds[i];
      s.short_cmd = 1'b1;
      exp_start_q.push_back(s);
    end
  endtask

  task automatic expect_txn(input logic n, input logic [23:0] a, input logic [31:0] wd,
                            input logic [2:0] sz, input logic we);
    start_t s;
    ack_t   k;
    logic   legal;
    legal = (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4);
    if (legal) begin
      s = '0;
      s.cmd   = we ? 8'h38 : 8'hEB;
      s.addr  = a;
      s.wdata = wd;
      s.size  = sz;
      s.rd_wr = ~we;
      s.qpi   = 1'b1;
      s.ws    = we ? 4'd0 : 4'd6;
      exp_start_q.push_back(s);
      if (!we) model_rdata[n] = ctrl_data(a);
    end
    k.who   = n;
    k.err   = ~legal;
    k.rdata = model_rdata[n];
    exp_ack_q.push_back(k);
    model_last = n;
  endtask

  // ---------------------------------------------------------------- controller model
  int   done_cyc  = 0;
  logic have_done = 1'b0;
  start_t cur_start;
  logic in_txn = 1'b0;

  initial begin
    logic abort;
    int   lat, hold;
    c_done  = 1'b0;
    c_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && c_start) begin
        logic [23:0] a;
        a     = c_addr;
        lat   = $urandom_range(1, 5);
        hold  = $urandom_range(1, 3);
        abort = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (!rst_n) begin abort = 1'b1; break; end
        end
        if (!abort) begin
          c_done    = 1'b1;
          c_rdata   = ctrl_data(a);
          done_cyc  = cyc;
          have_done = 1'b1;
          if (in_txn) begin
            check("fields_held_cmd", 32'(c_cmd), 32'(cur_start.cmd));
            if (!cur_start.init)
              check("fields_held_addr_size", {5'd0, c_addr, c_size}, {5'd0, cur_start.addr, cur_start.size});
            in_txn = 1'b0;
          end
          for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            if (!rst_n) break;
          end
        end
        c_done  = 1'b0;
        c_rdata = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  initial begin
    start_t e;
    ack_t   k;
    logic   got_err;
    logic [31:0] got_rdata;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn    = 1'b0;
        have_done = 1'b0;
      end else begin
        if (c_start) begin
          if (exp_start_q.size() == 0) begin
            fail_now("unexpected_c_start");
          end else begin
            e = exp_start_q.pop_front();
            cur_start = e;
            in_txn    = 1'b1;
            check("start_cmd", 32'(c_cmd), 32'(e.cmd));
            check("start_short_qpi_qspi", {29'd0, c_short_cmd, c_qpi, c_qspi},
                  {29'd0, e.short_cmd, e.qpi, 1'b0});
            check("start_init_done", 32'(init_done), {31'd0, ~e.init});
            if (!e.init) begin
              check("start_addr", 32'(c_addr), 32'(e.addr));
              check("start_size_rw_ws", {24'd0, c_size, c_rd_wr, c_wait_states},
                    {24'd0, e.size, e.rd_wr, e.ws});
              if (!e.rd_wr) check("start_wdata", c_wdata, e.wdata);
            end
            if (have_done) check("start_spacing_ge3", 32'((cyc - done_cyc) >= 3), 32'd1);
          end
        end
        if (r0_ack || r1_ack) begin
          check("ack_overlap", {31'd0, r0_ack & r1_ack}, 32'd0);
          if (exp_ack_q.size() == 0) begin
            fail_now("unexpected_ack");
          end else begin
            k = exp_ack_q.pop_front();
            check("ack_who", 32'(r1_ack), 32'(k.who));
            got_err   = k.who ? r1_err   : r0_err;
            got_rdata = k.who ? r1_rdata : r0_rdata;
            check("ack_err", 32'(got_err), 32'(k.err));
            check("ack_rdata", got_rdata, k.rdata);
            if (!k.err) check("ack_latency", 32'(cyc - done_cyc), 32'd1);
          end
        end else if (r0_err || r1_err) begin
          fail_now("err_without_ack");
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input logic n, input logic [23:0] a, input logic [31:0] wd,
                       input logic [2:0] sz, input logic we);
    if (n == 1'b0) begin
      r0_addr = a; r0_wdata = wd; r0_size = sz; r0_we = we; r0_req = 1'b1;
    end else begin
      r1_addr = a; r1_wdata = wd; r1_size = sz; r1_we = we; r1_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input logic n);
    int k;
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      if ((n == 1'b0) ? r0_ack : r1_ack) break;
      k++;
    end
    check(n ? "ack_timeout_r1" : "ack_timeout_r0", 32'(k < 400), 32'd1);
    if (n == 1'b0) r0_req = 1'b0;
    else           r1_req = 1'b0;
  endtask

  // mode 0: r0 only, 1: r1 only, 2: both raised in the same cycle
  task automatic run_round(input logic [1:0] mode,
                           input logic [23:0] a0, input logic [31:0] wd0, input logic [2:0] sz0, input logic we0,
                           input logic [23:0] a1, input logic [31:0] wd1, input logic [2:0] sz1, input logic we1);
    @(negedge clk);
    if (mode == 2'd2) begin
      if (model_last == 1'b1) begin
        expect_txn(1'b0, a0, wd0, sz0, we0);
        expect_txn(1'b1, a1, wd1, sz1, we1);
      end else begin
        expect_txn(1'b1, a1, wd1, sz1, we1);
        expect_txn(1'b0, a0, wd0, sz0, we0);
      end
    end else if (mode == 2'd0) begin
      expect_txn(1'b0, a0, wd0, sz0, we0);
    end else begin
      expect_txn(1'b1, a1, wd1, sz1, we1);
    end
    if (mode != 2'd1) drive(1'b0, a0, wd0, sz0, we0);
    if (mode != 2'd0) drive(1'b1, a1, wd1, sz1, we1);
    fork
      begin if (mode != 2'd1) wait_ack(1'b0); end
      begin if (mode != 2'd0) wait_ack(1'b1); end
    join
  endtask

  task automatic check_reset_values();
    check("rst_c_start", 32'(c_start), 32'd0);
    check("rst_c_addr", 32'(c_addr), 32'd0);
    check("rst_c_wdata", c_wdata, 32'd0);
    check("rst_c_size_cmd", {21'd0, c_size, c_cmd}, 32'd0);
    check("rst_c_flags", {28'd0, c_rd_wr, c_qspi, c_qpi, c_short_cmd}, 32'd0);
    check("rst_c_wait_states", 32'(c_wait_states), 32'd0);
    check("rst_ack_err", {28'd0, r0_ack, r0_err, r1_ack, r1_err}, 32'd0);
    check("rst_r0_rdata", r0_rdata, 32'd0);
    check("rst_r1_rdata", r1_rdata, 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [2:0] sz_tab [0:9] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd0, 3'd3, 3'd5, 3'd7};

  initial begin
    logic [31:0] r0r, r1r;
    logic [1:0]  mode;
    int          k;
    rst_n = 1'b0;
    r0_req = 1'b0; r0_addr = '0; r0_wdata = '0; r0_size = '0; r0_we = 1'b0;
    r1_req = 1'b0; r1_addr = '0; r1_wdata = '0; r1_size = '0; r1_we = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values();

    // Power-up, with an r0 read already pending during the init sequence.
    expect_init();
    rst_n = 1'b1;
    run_round(2'd0, 24'h001234, 32'h0, 3'd4, 1'b0, 24'h0, 32'h0, 3'd0, 1'b0);
    check("init_done_after_init", 32'(init_done), 32'd1);

    // Illegal-size write from r1.
    run_round(2'd1, 24'h0, 32'h0, 3'd0, 1'b0, 24'h00ABCD, 32'h1122_3344, 3'd3, 1'b1);

    // Both requesting, twice: r0, r1, r0, r1.
    run_round(2'd2, 24'h100000, 32'hA0A0_A0A0, 3'd4, 1'b0, 24'h200000, 32'hB1B1_B1B1, 3'd2, 1'b1);
    run_round(2'd2, 24'h300010, 32'hC2C2_C2C2, 3'd1, 1'b1, 24'h400020, 32'hD3D3_D3D3, 3'd4, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      r0r  = $urandom;
      r1r  = $urandom;
      mode = 2'($urandom_range(0, 2));
      run_round(mode,
                r0r[23:0], $urandom, sz_tab[$urandom_range(0, 9)], r0r[31],
                r1r[23:0], $urandom, sz_tab[$urandom_range(0, 9)], r1r[31]);
    end

    // Reset while a read sits in WAIT: no ack, outputs cleared, init reruns.
    @(negedge clk);
    expect_txn(1'b0, 24'h0055AA, 32'h0, 3'd4, 1'b0);
    drive(1'b0, 24'h0055AA, 32'h0, 3'd4, 1'b0);
    k = 0;
    while (k < 100 && !c_start) begin
      @(negedge clk);
      k++;
    end
    check("start_before_reset", 32'(c_start), 32'd1);
    @(negedge clk);
    rst_n  = 1'b0;
    r0_req = 1'b0;
    exp_start_q.delete();
    exp_ack_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values();
    expect_init();
    rst_n = 1'b1;
    run_round(2'd2, 24'h0A0B0C, 32'h5555_AAAA, 3'd2, 1'b1, 24'h0C0B0A, 32'h0, 3'd4, 1'b0);

    repeat (10) @(negedge clk);
    check("start_queue_empty", 32'(exp_start_q.size()), 32'd0);
    check("ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ef_psram_arb.md
EF_PSRAM_ARB -- requirements
Module: ef_psram_arb

Interface
REQ-001 Parameter RD_WAIT, default 6: wait-state count driven on c_wait_states for reads (4 bits).
REQ-002 Parameter INIT_EN, default 1: 1 runs the power-up command sequence; 0 skips it.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rN_req  in  1  request from requester N (N=0,1), held high until rN_ack.
REQ-006 rN_addr  in  24  byte address, held stable while rN_req is high.
REQ-007 rN_wdata  in  32  write data, byte 0 in [7:0].
REQ-008 rN_size  in  3  byte count; legal values are 1, 2 and 4.
REQ-009 rN_we  in  1  1 = write, 0 = read.
REQ-010 rN_ack  out  1  one-cycle completion pulse.
REQ-011 rN_err  out  1  one-cycle pulse with rN_ack for an illegal size.
REQ-012 rN_rdata  out  32  read data, valid in the rN_ack cycle.
REQ-013 c_start  out  1  one-cycle transaction start to the QSPI PSRAM controller.
REQ-014 c_addr, c_wdata, c_size, c_cmd, c_rd_wr, c_qspi, c_qpi, c_short_cmd, c_wait_states  out  24/32/3/8/1/1/1/1/4  controller command fields.
REQ-015 c_done  in  1  controller done; may stay high for up to 2 cycles after completion.
REQ-016 c_rdata  in  32  controller read data.
REQ-017 init_done  out  1  high once the device is in QPI mode.
REQ-018 busy  out  1  high in every state except ARB.

Function
REQ-019 The FSM SHALL have states INIT_ISSUE, INIT_WAIT, INIT_GAP, ARB, ISSUE, WAIT, GAP, ERR.
REQ-020 Init sequence with INIT_EN=1:
- three short commands in SPI mode: 0x66, then 0x99, then 0x35
- each command uses c_short_cmd=1, c_qpi=0, c_qspi=0
- each command is followed by WAIT then a 2-cycle GAP
- after the third GAP: init_done=1 and c_qpi=1 permanently; enter ARB.
REQ-021 With INIT_EN=0, the first cycle after reset release SHALL set init_done=1 and c_qpi=1 and enter ARB.
REQ-022 Requests arriving before init_done SHALL stay pending; they are not acked or dropped.
REQ-023 Arbitration in ARB is round-robin:
- a single requester is granted
- when both request, the requester not granted last wins
- after reset r0 has priority.
REQ-024 Grant at edge k SHALL latch the granted fields into c_* registers; c_start=1 in cycle k+1 (ISSUE) only; then WAIT.
REQ-025 Normal-transaction field values:
- reads: c_cmd=0xEB, c_rd_wr=1, c_wait_states=RD_WAIT
- writes: c_cmd=0x38, c_rd_wr=0, c_wait_states=0
- always: c_short_cmd=0, c_qspi=0.
REQ-026 All c_* fields SHALL stay constant from ISSUE until WAIT is exited.
REQ-027 WAIT completion:
- WAIT samples c_done
- first high sample at edge m: registers c_rdata into the granted rN_rdata
- asserts rN_ack in cycle m+1
- enters GAP.
REQ-028 GAP SHALL last exactly 2 cycles and ignore c_done; no c_start is issued within 2 cycles of done.
REQ-029 Illegal size (0, 3, 5-7):
- the grant goes to ERR instead of ISSUE
- rN_ack=1 and rN_err=1 for one cycle
- no c_start; return to ARB
- the round-robin pointer still updates.
REQ-030 Acks to both requesters SHALL never occur in the same cycle.
REQ-031 rN_rdata SHALL hold its value until the next read completes for that requester.
REQ-032 A request deasserted before its ack is protocol misuse; the transaction in flight still completes and acks.

Reset
REQ-033 While rst_n=0, the following SHALL be 0: c_start, c_addr, c_wdata, c_size, c_cmd, c_rd_wr, c_qspi, c_qpi, c_short_cmd, c_wait_states, rN_ack, rN_err, rN_rdata, init_done.
REQ-034 Reset state SHALL be INIT_ISSUE (INIT_EN=1) or ARB-entry (INIT_EN=0); busy=1 during reset; the round-robin pointer favours r0.
REQ-035 Reset mid-transaction SHALL abandon it without ack; the init sequence reruns.

Verification
REQ-036 Power-up with a controller model:
- c_start pulses carry c_cmd 0x66, 0x99, 0x35, each with c_short_cmd=1
- starts are separated by done plus at least 2 GAP cycles
- then init_done=1.
REQ-037 r0 read, addr 0x001234, size 4, c_rdata=0xDEADBEEF:
- c_cmd=0xEB, c_wait_states=6, c_qpi=1
- r0_ack one cycle after the first c_done, r0_rdata=0xDEADBEEF.
REQ-038 r0 and r1 request together, both held: grants alternate r0, r1, r0, r1 over four transactions; acks never overlap.
REQ-039 r1 write, size 3: r1_ack=r1_err=1 for one cycle; no c_start.
REQ-040 c_done held 2 cycles: exactly one ack; next c_start no earlier than 3 cycles after the first c_done.
REQ-041 rst_n pulsed low during WAIT: outputs at reset values; no ack; init sequence reruns.
